// File: rtl/xillyusb_read32_arbiter_if.sv
// Producer-side handshake and XillyUSB user_r_read_32 FIFO signals shared by
// the read32 arbiter and whatever drives it.
interface xillyusb_read32_arbiter_if #(
  parameter int unsigned N_SRC = 4
);
  logic [32*N_SRC-1:0] src_data;
  logic [N_SRC-1:0]    src_valid;
  logic [N_SRC-1:0]    src_last;
  logic [N_SRC-1:0]    src_eof;
  logic [N_SRC-1:0]    src_enable;
  logic [N_SRC-1:0]    src_ready;
  logic [1:0]          grant_id;
  logic                user_r_read_32_open;
  logic                user_r_read_32_rden;
  logic [31:0]         user_r_read_32_data;
  logic                user_r_read_32_empty;
  logic                user_r_read_32_eof;
  logic [32*N_SRC-1:0] stat_words;

  modport master (
    output src_data, src_valid, src_last, src_eof, src_enable,
    output user_r_read_32_open, user_r_read_32_rden,
    input  src_ready, grant_id, user_r_read_32_data, user_r_read_32_empty,
    input  user_r_read_32_eof, stat_words
  );

  modport slave (
    input  src_data, src_valid, src_last, src_eof, src_enable,
    input  user_r_read_32_open, user_r_read_32_rden,
    output src_ready, grant_id, user_r_read_32_data, user_r_read_32_empty,
    output user_r_read_32_eof, stat_words
  );
endinterface

// File: rtl/xillyusb_read32_arbiter.sv
// Round-robin burst arbiter feeding the XillyUSB user_r_read_32 stream through
// a small non-FWFT FIFO. Define ARB_STATS_EN for per-source accepted-word counters.
module xillyusb_read32_arbiter #(
  parameter int unsigned N_SRC       = 4,
  parameter int unsigned BURST_WORDS = 64,
  parameter int unsigned FIFO_AW     = 4
) (
  input logic                      bus_clk,
  input logic                      bus_rst,
  xillyusb_read32_arbiter_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_W = (FIFO_AW + 1)'(DEPTH);
  localparam logic [7:0] LAST_CNT = 8'(BURST_WORDS - 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]         state, state_nxt;
  logic [1:0]         grant_id, rr_ptr;
  logic [7:0]         burst_cnt;
  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count, count_nxt;
  logic [31:0]        rd_data;
  logic               eof;

  logic               open, g_valid, g_last, g_enable, burst_ok, fifo_room;
  logic               accept, pop, grant_fire, all_eof, pick_found;
  logic [31:0]        g_data;
  logic [1:0]         pick_id, pick_nxt;
  logic [N_SRC-1:0]   cand, ready;

  assign open      = bus.user_r_read_32_open;
  assign cand      = bus.src_valid & bus.src_enable;
  assign all_eof   = &(bus.src_eof | ~bus.src_enable);
  assign fifo_room = (count < DEPTH_W);
  assign burst_ok  = (state == BURST) && open && g_enable;
  assign accept    = burst_ok && fifo_room && g_valid;
  assign pop       = bus.user_r_read_32_rden && (count != '0);
  assign grant_fire = (state == IDLE) && open && pick_found;

  always_comb begin
    g_valid  = 1'b0;
    g_last   = 1'b0;
    g_enable = 1'b0;
    g_data   = '0;
    ready    = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (grant_id == 2'(i)) begin
        g_valid  = bus.src_valid[i];
        g_last   = bus.src_last[i];
        g_enable = bus.src_enable[i];
        g_data   = bus.src_data[32*i +: 32];
        ready[i] = burst_ok && fifo_room;
      end
    end
  end

  // Search order starts at rr_ptr (one past the last grant) and wraps.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    pick_nxt   = rr_ptr;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (!pick_found && cand[i] && ((32'(rr_ptr) + k) % N_SRC) == i) begin
          pick_found = 1'b1;
          pick_id    = 2'(i);
          pick_nxt   = 2'((i + 1) % N_SRC);
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (grant_fire) state_nxt = BURST;
      BURST: begin
        if (!open || !g_enable || !g_valid)
          state_nxt = IDLE;
        else if (accept && (g_last || burst_cnt == LAST_CNT))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!open)
      state_nxt = IDLE;
  end

  always_comb begin
    if (!open)
      count_nxt = '0;
    else
      count_nxt = count + (FIFO_AW + 1)'(accept) - (FIFO_AW + 1)'(pop);
  end

  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      state     <= IDLE;
      grant_id  <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_data   <= '0;
      eof       <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      // Built from next-cycle state so eof can never coincide with empty=0.
      eof   <= (count_nxt == '0) && (state_nxt == IDLE) && all_eof;
      if (grant_fire) begin
        grant_id  <= pick_id;
        rr_ptr    <= pick_nxt;
        burst_cnt <= '0;
      end else if (accept) begin
        burst_cnt <= burst_cnt + 8'd1;
      end
      if (!open) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (accept) wr_ptr <= wr_ptr + FIFO_AW'(1);
        if (pop)    rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      if (pop)
        rd_data <= mem[rd_ptr];
    end
  end

  always_ff @(posedge bus_clk) begin
    if (accept)
      mem[wr_ptr] <= g_data;
  end

  assign bus.src_ready            = ready;
  assign bus.grant_id             = grant_id;
  assign bus.user_r_read_32_data  = rd_data;
  assign bus.user_r_read_32_empty = (count == '0);
  assign bus.user_r_read_32_eof   = eof;

`ifdef ARB_STATS_EN
  logic [31:0] stat [N_SRC];

  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      for (int unsigned i = 0; i < N_SRC; i++) stat[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_SRC; i++)
        if (accept && grant_id == 2'(i) && stat[i] != '1)
          stat[i] <= stat[i] + 32'd1;
    end
  end

  always_comb begin
    bus.stat_words = '0;
    for (int unsigned i = 0; i < N_SRC; i++)
      bus.stat_words[32*i +: 32] = stat[i];
  end
`else
  assign bus.stat_words = '0;
`endif
endmodule

// File: tb/tb_xillyusb_read32_arbiter.sv
// Directed bench for xillyusb_read32_arbiter: arbitration order, burst limits,
// FIFO full/drain, eof, open flush, statistics and asynchronous reset.
`timescale 1ns/1ps
module tb_xillyusb_read32_arbiter;
  localparam int unsigned N = 4;

  logic bus_clk = 1'b0;
  logic bus_rst = 1'b1;
  always #5 bus_clk = ~bus_clk;

  xillyusb_read32_arbiter_if #(.N_SRC(N)) bus ();

  xillyusb_read32_arbiter #(
    .N_SRC(N),
    .BURST_WORDS(4),
    .FIFO_AW(4)
  ) dut (
    .bus_clk(bus_clk),
    .bus_rst(bus_rst),
    .bus(bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;

  logic [23:0]  seq     [N];
  logic [23:0]  limit   [N];
  logic [23:0]  last_at [N];
  logic [N-1:0] vmask;
  logic [N-1:0] acc_q  = '0;
  logic         fire_q = 1'b0;
  logic         clr;
  logic [31:0]  host_q [$];

  // Each producer emits {src, seq}; valid while below its limit.
  always_comb begin
    bus.src_data  = '0;
    bus.src_valid = '0;
    bus.src_last  = '0;
    for (int i = 0; i < N; i++) begin
      bus.src_data[32*i +: 32] = {8'(i), seq[i]};
      bus.src_valid[i]         = vmask[i] && (seq[i] < limit[i]);
      bus.src_last[i]          = (seq[i] == last_at[i]);
    end
  end

  always @(negedge bus_clk) begin
    acc_q = bus.src_valid & bus.src_ready;
    if (fire_q) host_q.push_back(bus.user_r_read_32_data);
    fire_q = bus.user_r_read_32_rden & ~bus.user_r_read_32_empty;
  end

  always @(posedge bus_clk) begin
    for (int i = 0; i < N; i++) begin
      if (clr)           seq[i] <= '0;
      else if (acc_q[i]) seq[i] <= seq[i] + 24'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge bus_clk);
    #1;
  endtask

  task automatic wait_host(input int unsigned n, input int unsigned budget);
    int unsigned c = 0;
    while (host_q.size() < n && c < budget) begin
      tick(1);
      c++;
    end
    if (host_q.size() < n) check("host_timeout", 32'(host_q.size()), 32'(n));
  endtask

  task automatic wait_seq(input int src, input int unsigned v, input int unsigned budget);
    int unsigned c = 0;
    while (32'(seq[src]) < v && c < budget) begin
      tick(1);
      c++;
    end
    if (32'(seq[src]) < v) check("seq_timeout", 32'(seq[src]), 32'(v));
  endtask

  task automatic wait_busy(input int unsigned budget);
    int unsigned c = 0;
    while (!(bus.src_ready != '0 && !bus.user_r_read_32_empty) && c < budget) begin
      tick(1);
      c++;
    end
    if (bus.src_ready == '0) check("busy_timeout", 32'(bus.src_ready), 32'hF);
  endtask

  task automatic clear_seq();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.src_ready), 32'd0);
    check({tag, "_grant"}, 32'(bus.grant_id), 32'd0);
    check({tag, "_data"},  bus.user_r_read_32_data, 32'd0);
    check({tag, "_empty"}, 32'(bus.user_r_read_32_empty), 32'd1);
    check({tag, "_eof"},   32'(bus.user_r_read_32_eof), 32'd0);
    for (int i = 0; i < N; i++)
      check({tag, "_stat"}, bus.stat_words[32*i +: 32], 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.src_enable          = '0;
    bus.src_eof             = '0;
    bus.user_r_read_32_open = 1'b0;
    bus.user_r_read_32_rden = 1'b0;
    vmask = '0;
    clr   = 1'b1;
    for (int i = 0; i < N; i++) begin
      limit[i]   = '0;
      last_at[i] = '1;
    end
    tick(3);
    check_reset_outputs("reset");
    bus_rst = 1'b0;
    tick(1);
    clr = 1'b0;

    // Round robin over all four, four words per grant
    for (int i = 0; i < N; i++) limit[i] = 24'd1000;
    host_q.delete();
    bus.src_enable          = 4'hF;
    vmask                   = 4'hF;
    bus.user_r_read_32_rden = 1'b1;
    bus.user_r_read_32_open = 1'b1;
    wait_host(32, 200);
    for (int k = 0; k < 32; k++)
      check("rr_word", host_q[k], {8'((k / 4) % 4), 24'(((k / 16) * 4) + (k % 4))});
    vmask = '0;
    tick(2);
    bus.user_r_read_32_open = 1'b0;
    bus.user_r_read_32_rden = 1'b0;
    tick(3);
    clear_seq();
    host_q.delete();

    // src_last ends the grant early
    bus.src_enable          = 4'b0010;
    vmask                   = 4'b0010;
    limit[1]                = 24'd5;
    last_at[1]              = 24'd2;
    bus.user_r_read_32_open = 1'b1;
    wait_seq(1, 3, 50);
    check("last_ready_drop", 32'(bus.src_ready), 32'd0);
    check("last_grant", 32'(bus.grant_id), 32'd1);
    wait_seq(1, 5, 50);
    tick(2);
    check("last_idle_ready", 32'(bus.src_ready), 32'd0);
    check("last_not_empty", 32'(bus.user_r_read_32_empty), 32'd0);
    bus.user_r_read_32_rden = 1'b1;
    tick(4);
    check("last_empty_4pops", 32'(bus.user_r_read_32_empty), 32'd0);
    tick(1);
    bus.user_r_read_32_rden = 1'b0;
    check("last_empty_5pops", 32'(bus.user_r_read_32_empty), 32'd1);
    tick(2);
    check("last_host_count", 32'(host_q.size()), 32'd5);
    for (int k = 0; k < 5; k++)
      check("last_word", host_q[k], {8'd1, 24'(k)});
    vmask = '0;
    bus.user_r_read_32_open = 1'b0;
    last_at[1] = '1;
    tick(2);
    clear_seq();

    // FIFO fills to depth with no reads, then drains in order
    bus.src_enable          = 4'b0001;
    vmask                   = 4'b0001;
    limit[0]                = 24'd100;
    bus.user_r_read_32_open = 1'b1;
    tick(40);
    check("full_accepted", 32'(seq[0]), 32'd16);
    check("full_ready", 32'(bus.src_ready), 32'd0);
    check("full_not_empty", 32'(bus.user_r_read_32_empty), 32'd0);
    vmask = '0;
    tick(2);
    host_q.delete();
    bus.user_r_read_32_rden = 1'b1;
    tick(15);
    check("drain_empty_15", 32'(bus.user_r_read_32_empty), 32'd0);
    tick(1);
    bus.user_r_read_32_rden = 1'b0;
    check("drain_empty_16", 32'(bus.user_r_read_32_empty), 32'd1);
    tick(2);
    check("drain_count", 32'(host_q.size()), 32'd16);
    for (int k = 0; k < 16; k++)
      check("drain_word", host_q[k], {8'd0, 24'(k)});
    bus.user_r_read_32_open = 1'b0;
    tick(2);
    clear_seq();

    // Enable mask 0101: last grant was src0, so src2 leads, then alternate
    for (int i = 0; i < N; i++) limit[i] = 24'd1000;
    host_q.delete();
    bus.src_enable          = 4'b0101;
    vmask                   = 4'hF;
    bus.user_r_read_32_rden = 1'b1;
    bus.user_r_read_32_open = 1'b1;
    wait_host(16, 200);
    for (int k = 0; k < 16; k++)
      check("mask_word", host_q[k],
            {(((k / 4) % 2) == 0) ? 8'd2 : 8'd0, 24'(((k / 8) * 4) + (k % 4))});

    // eof tracks the enabled producers once drained
    vmask = '0;
    tick(10);
    check("eof_pending", 32'(bus.user_r_read_32_eof), 32'd0);
    bus.src_eof = 4'b0101;
    tick(1);
    check("eof_set", 32'(bus.user_r_read_32_eof), 32'd1);
    check("eof_empty", 32'(bus.user_r_read_32_empty), 32'd1);
    bus.src_eof = 4'b0001;
    tick(1);
    check("eof_clear", 32'(bus.user_r_read_32_eof), 32'd0);

    // Closing the file mid-burst flushes
    bus.src_eof             = '0;
    bus.user_r_read_32_rden = 1'b0;
    bus.src_enable          = 4'hF;
    vmask                   = 4'hF;
    wait_busy(40);
    bus.user_r_read_32_open = 1'b0;
    tick(1);
    check("close_empty", 32'(bus.user_r_read_32_empty), 32'd1);
    check("close_ready", 32'(bus.src_ready), 32'd0);
    tick(1);
    check("close_ready_hold", 32'(bus.src_ready), 32'd0);

    // Statistics after a fresh reset
    vmask   = '0;
    bus_rst = 1'b1;
    tick(1);
    bus_rst = 1'b0;
    clear_seq();
    host_q.delete();
    bus.src_enable          = 4'b0100;
    vmask                   = 4'b0100;
    limit[2]                = 24'd100;
    bus.user_r_read_32_rden = 1'b1;
    bus.user_r_read_32_open = 1'b1;
    wait_seq(2, 100, 400);
    tick(3);
    for (int i = 0; i < N; i++) begin
`ifdef ARB_STATS_EN
      check("stat_words", bus.stat_words[32*i +: 32], (i == 2) ? 32'd100 : 32'd0);
`else
      check("stat_words", bus.stat_words[32*i +: 32], 32'd0);
`endif
    end
    check("stat_host_count", 32'(host_q.size()), 32'd100);
    check("stat_last_word", host_q[99], {8'd2, 24'd99});

    // Asynchronous reset in the middle of a burst
    limit[2]                = 24'd1000;
    bus.user_r_read_32_rden = 1'b0;
    bus.src_enable          = 4'hF;
    vmask                   = 4'hF;
    wait_busy(40);
    bus_rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    tick(2);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
